// File: rtl/hub75_fb_writer_if.sv
// Bundles the producer-side word handshake and the pixel memory write port
// of the HUB75 framebuffer writer.
interface hub75_fb_writer_if;
  logic        wr_valid;
  logic [31:0] wr_data;
  logic        wr_ready;
  logic        mem_busy;
  logic        mem_wr;
  logic [14:0] mem_addr;
  logic [15:0] mem_wdata;

  // master drives words in and consumes pixel writes; slave is the writer block
  modport master (
    output wr_valid, wr_data, mem_busy,
    input  wr_ready, mem_wr, mem_addr, mem_wdata
  );

  modport slave (
    input  wr_valid, wr_data, mem_busy,
    output wr_ready, mem_wr, mem_addr, mem_wdata
  );
endinterface

// File: rtl/hub75_fb_writer.sv
// Buffers 32-bit two-pixel words in a small FIFO and drains them as single
// 16-bit pixel writes into a wrapping framebuffer address space.
module hub75_fb_writer #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [14:0] FB_LAST    = 15'h7FFF
) (
  input  logic                          pclk,
  input  logic                          presetn,
  hub75_fb_writer_if.slave              bus,
  input  logic                          addr_load,
  input  logic [14:0]                   start_addr,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  input  logic                          clr_overflow,
  output logic                          frame_done,
  output logic                          idle
);

  localparam int unsigned     AW        = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]     DEPTH_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, LO, HI} state_t;

  state_t        state;
  logic [31:0]   fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;
  logic [AW:0]   count;
  logic [31:0]   hold;
  logic [14:0]   ptr;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          write_now;

  assign full         = (count == DEPTH_CNT);
  assign empty        = (count == '0);
  assign push         = bus.wr_valid && !full;
  assign bus.wr_ready = !full;
  assign fifo_level   = count;
  assign idle         = (state == IDLE) && empty;
  assign write_now    = ((state == LO) || (state == HI)) && !bus.mem_busy;
  // The next word is fetched either from IDLE or at the edge the high pixel leaves
  assign pop          = !empty && ((state == IDLE) || ((state == HI) && !bus.mem_busy));

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      wr_idx <= '0;
      rd_idx <= '0;
      count  <= '0;
    end else begin
      if (push) wr_idx <= wr_idx + 1'b1;
      if (pop)  rd_idx <= rd_idx + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge pclk) begin
    if (push) fifo_mem[wr_idx] <= bus.wr_data;
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      overflow <= 1'b0;
    end else if (bus.wr_valid && full) begin
      overflow <= 1'b1;
    end else if (clr_overflow) begin
      overflow <= 1'b0;
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state         <= IDLE;
      hold          <= '0;
      ptr           <= '0;
      bus.mem_wr    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      frame_done    <= 1'b0;
    end else begin
      bus.mem_wr <= 1'b0;
      frame_done <= 1'b0;
      if (write_now) begin
        bus.mem_wr    <= 1'b1;
        bus.mem_addr  <= ptr;
        bus.mem_wdata <= (state == LO) ? hold[15:0] : hold[31:16];
        frame_done    <= (ptr == FB_LAST);
      end

      // A load retargets the next pixel even if a write uses the old ptr this cycle
      if (addr_load) begin
        ptr <= start_addr;
      end else if (write_now) begin
        ptr <= (ptr == FB_LAST) ? '0 : ptr + 1'b1;
      end

      if (pop) hold <= fifo_mem[rd_idx];

      case (state)
        IDLE:    if (pop) state <= LO;
        LO:      if (!bus.mem_busy) state <= HI;
        HI:      if (!bus.mem_busy) state <= empty ? IDLE : LO;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
